// File: rtl/pid_sched_pkg.sv
// pid_sched_pkg: shared widths, FSM state type and saturation helper for the PID scheduler
package pid_sched_pkg;
  localparam int NUM_CH = 4;
  localparam int DW = 16;
  localparam int EW = DW + 1;
  localparam int CW = $clog2(NUM_CH);
  localparam logic signed [EW-1:0] MAXV = EW'(2 ** (DW - 1) - 1);
  localparam logic signed [EW-1:0] MINV = EW'(-(2 ** (DW - 1)));
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic logic signed [DW-1:0] sat16(input logic signed [EW-1:0] x);
    return x > MAXV ? MAXV[DW-1:0] : x < MINV ? MINV[DW-1:0] : x[DW-1:0];
  endfunction
endpackage

// File: rtl/pid_comp_core.sv
// pid_comp_core: shared combinational compensator, one channel evaluated per use
module pid_comp_core
  import pid_sched_pkg::*;
(
  input  logic signed [DW-1:0] err_prev,
  input  logic signed [DW-1:0] acc_prev,
  input  logic signed [DW-1:0] set,
  input  logic signed [DW-1:0] sense,
  output logic signed [DW-1:0] mot_new,
  output logic signed [DW-1:0] err_new
);
  logic signed [EW-1:0] w_sum;
  logic signed [EW-1:0] w_diff;
  assign w_sum   = EW'(err_prev) + EW'(acc_prev >>> 2);
  assign w_diff  = EW'(set) - EW'(sense);
  assign mot_new = sat16(w_sum);
  assign err_new = sat16(w_diff);
endmodule

// File: rtl/motor_pid_sched.sv
// motor_pid_sched: time-shares one compensator over four motor channels per control tick
module motor_pid_sched
  import pid_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_CH-1:0]      en,
  input  logic [NUM_CH*DW-1:0]   rpm_set,
  input  logic [NUM_CH*DW-1:0]   rpm_sense,
  output logic [NUM_CH*DW-1:0]   mot_set,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);
  state_t                   r_state;
  logic [CW-1:0]            r_ch;
  logic [NUM_CH-1:0]        r_en;
  logic [NUM_CH-1:0][DW-1:0] r_set;
  logic [NUM_CH-1:0][DW-1:0] r_sense;
  logic [NUM_CH-1:0][DW-1:0] r_err;
  logic [NUM_CH-1:0][DW-1:0] r_acc;
  logic signed [DW-1:0]     w_mot_new;
  logic signed [DW-1:0]     w_err_new;

  pid_comp_core u_core (
    .err_prev (r_err[r_ch]),
    .acc_prev (r_acc[r_ch]),
    .set      (r_set[r_ch]),
    .sense    (r_sense[r_ch]),
    .mot_new  (w_mot_new),
    .err_new  (w_err_new)
  );

  // DONE spans two cycles: first edge publishes mot_set, second retires busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_en    <= '0;
      r_set   <= '0;
      r_sense <= '0;
      r_err   <= '0;
      r_acc   <= '0;
      mot_set <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (start && r_state != IDLE) overrun <= 1'b1;
      case (r_state)
        IDLE: if (start) begin
          r_en    <= en;
          r_set   <= rpm_set;
          r_sense <= rpm_sense;
          r_ch    <= '0;
          busy    <= 1'b1;
          r_state <= CALC;
        end
        CALC: begin
          r_acc[r_ch] <= r_en[r_ch] ? w_mot_new : '0;
          r_err[r_ch] <= r_en[r_ch] ? w_err_new : '0;
          r_ch        <= r_ch + 1'b1;
          if (r_ch == CW'(NUM_CH - 1)) r_state <= DONE;
        end
        DONE: if (!done) begin
          mot_set <= r_acc;
          done    <= 1'b1;
        end else begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_motor_pid_sched.sv
// tb_motor_pid_sched: scoreboard bench, expected mot_set and done cycle queued per tick
module tb_motor_pid_sched;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [3:0]  en = 0;
  logic [63:0] rpm_set = 0;
  logic [63:0] rpm_sense = 0;
  logic [63:0] mot_set;
  logic        busy, done, overrun;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [63:0] mot;
    int          at;
  } exp_t;
  exp_t q[$];

  motor_pid_sched dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .en        (en),
    .rpm_set   (rpm_set),
    .rpm_sense (rpm_sense),
    .mot_set   (mot_set),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mot_set", mot_set, e.mot);
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic tick(input logic [63:0] exp, input bit disturb);
    logic [63:0] s_set, s_sense;
    logic [3:0]  s_en;
    @(negedge clk);
    start = 1;
    q.push_back('{mot: exp, at: cyc + 6});
    @(negedge clk);
    start = 0;
    chk("busy_rise", busy, 1);
    s_set = rpm_set;
    s_sense = rpm_sense;
    s_en = en;
    if (disturb) begin
      rpm_set = {$urandom, $urandom};
      rpm_sense = {$urandom, $urandom};
      en = ~en;
    end
    repeat (5) @(negedge clk);
    chk("busy_hold", busy, 1);
    rpm_set = s_set;
    rpm_sense = s_sense;
    en = s_en;
    @(negedge clk);
    chk("busy_fall", busy, 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_hold", {mot_set, busy, done, overrun}, 80'h0);
    reset = 0;
    @(negedge clk);
    chk("reset_state", {mot_set, busy, done, overrun}, 80'h0);

    en = 4'b0001; rpm_set = 64'd1000; rpm_sense = 0;
    tick(64'd0, 0);
    tick(64'd1000, 0);
    tick(64'd1250, 1);
    tick(64'd1312, 0);

    do_reset();
    en = 4'b0001; rpm_set = {48'h0, 16'h7FFF}; rpm_sense = {48'h0, 16'h8000};
    tick(64'd0, 0);
    tick({48'h0, 16'h7FFF}, 0);
    tick({48'h0, 16'h7FFF}, 0);

    do_reset();
    en = 4'b0001; rpm_set = {48'h0, 16'hFC18}; rpm_sense = 0;
    tick(64'd0, 0);
    tick({48'h0, 16'hFC18}, 0);
    tick({48'h0, 16'hFB1E}, 0);

    do_reset();
    en = 4'b0001; rpm_set = {48'h0, 16'hFFFF}; rpm_sense = 0;
    tick(64'd0, 0);
    tick({48'h0, 16'hFFFF}, 0);
    tick({48'h0, 16'hFFFE}, 0);

    do_reset();
    en = 4'b0101; rpm_set = {4{16'd500}}; rpm_sense = 0;
    tick(64'd0, 0);
    tick({16'd0, 16'd500, 16'd0, 16'd500}, 0);
    tick({16'd0, 16'd625, 16'd0, 16'd625}, 0);
    tick({16'd0, 16'd656, 16'd0, 16'd656}, 0);

    do_reset();
    en = 4'b1111;
    rpm_set = {16'hFF38, 16'd300, 16'd100, 16'd0};
    rpm_sense = {16'd0, 16'd100, 16'd0, 16'd50};
    tick(64'd0, 0);
    tick({16'hFF38, 16'h00C8, 16'h0064, 16'hFFCE}, 1);
    tick({16'hFF06, 16'h00FA, 16'h007D, 16'hFFC1}, 1);

    do_reset();
    chk("overrun_clear", overrun, 0);
    en = 4'b0001; rpm_set = 64'd1000; rpm_sense = 0;
    @(negedge clk);
    start = 1;
    q.push_back('{mot: 64'd0, at: cyc + 6});
    repeat (3) @(negedge clk);
    start = 0;
    chk("overrun_set", overrun, 1);
    repeat (5) @(negedge clk);
    chk("busy_idle_after_hold", busy, 0);
    tick(64'd1000, 0);
    chk("overrun_sticky", overrun, 1);

    do_reset();
    en = 4'b0001; rpm_set = 64'd1000; rpm_sense = 0;
    @(negedge clk);
    start = 1;
    q.push_back('{mot: 64'd0, at: cyc + 6});
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    start = 1;
    @(negedge clk);
    q.push_back('{mot: 64'd1000, at: cyc + 6});
    chk("overrun_on_return", overrun, 1);
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);

    do_reset();
    en = 4'b0001; rpm_set = 64'd1000; rpm_sense = 0;
    tick(64'd0, 0);
    tick(64'd1000, 0);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    chk("reset_midcalc", {mot_set, busy, done, overrun}, 80'h0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (8) @(negedge clk);
    chk("no_done_after_abort", {mot_set, busy, done}, 80'h0);
    tick(64'd0, 0);
    tick(64'd1000, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
